// File: rtl/cf_pio_sequencer.sv
// Timed ATA PIO sequencer: turns single-word Avalon-MM transfers into task-file
// cycles with programmable setup/pulse/hold/recovery and IORDY stretching.
module cf_pio_sequencer #(
   parameter int T_SETUP       = 4,
   parameter int T_PULSE       = 9,
   parameter int T_HOLD        = 2,
   parameter int T_RECOVER     = 7,
   parameter int IORDY_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        present,
   input  logic [3:0]  av_address,
   input  logic        av_chipselect_n,
   input  logic        av_read_n,
   input  logic        av_write_n,
   input  logic [15:0] av_writedata,
   output logic [15:0] av_readdata,
   output logic        av_waitrequest,
   output logic        timeout,
   output logic [2:0]  addr,
   output logic [1:0]  cs_n,
   output logic        iord_n,
   output logic        iowr_n,
   output logic [15:0] data_out,
   output logic        data_oe,
   input  logic [15:0] data_in,
   input  logic        iordy,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_WAIT_RDY, S_HOLD, S_RECOVER
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  phase_q;
   logic [9:0]  rdy_cnt_q;
   logic [3:0]  lat_addr_q;
   logic        lat_write_q;
   logic [15:0] lat_data_q;

   logic req, phase_last, rdy_last, strobe_on, bus_on, abort;
   logic rd_done, to_hit;

   // Avalon handshake: the master holds its controls until it sees
   // av_waitrequest low; that cycle completes the transfer and av_readdata is
   // valid in it. The no-card abort completes at once and its 16'hFFFF lands
   // in av_readdata on the following cycle.
   assign req        = ~av_chipselect_n & (~av_read_n | ~av_write_n);
   assign phase_last = (phase_q == 4'd0);
   assign rdy_last   = (rdy_cnt_q == 10'(IORDY_TIMEOUT - 1));
   assign strobe_on  = (state_q == S_PULSE) || (state_q == S_WAIT_RDY);
   assign bus_on     = strobe_on || (state_q == S_SETUP) || (state_q == S_HOLD);
   assign abort      = ~present & (strobe_on || (state_q == S_SETUP));
   assign rd_done    = ((state_q == S_PULSE) & phase_last & iordy) |
                       ((state_q == S_WAIT_RDY) & iordy);
   assign to_hit     = (state_q == S_WAIT_RDY) & ~iordy & rdy_last;

   function automatic logic [3:0] phase_len(input state_t s);
      case (s)
         S_SETUP:   phase_len = 4'(T_SETUP - 1);
         S_PULSE:   phase_len = 4'(T_PULSE - 1);
         S_HOLD:    phase_len = 4'(T_HOLD - 1);
         S_RECOVER: phase_len = 4'(T_RECOVER - 1);
         default:   phase_len = 4'd0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (req & present) state_d = S_SETUP;
         S_SETUP:    if (!present) state_d = S_HOLD;
                     else if (phase_last) state_d = S_PULSE;
         S_PULSE:    if (!present) state_d = S_HOLD;
                     else if (phase_last) state_d = iordy ? S_HOLD : S_WAIT_RDY;
         S_WAIT_RDY: if (!present || iordy || rdy_last) state_d = S_HOLD;
         S_HOLD:     if (phase_last) state_d = S_RECOVER;
         S_RECOVER:  if (phase_last) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q     <= 4'd0;
         rdy_cnt_q   <= 10'd0;
         lat_addr_q  <= 4'd0;
         lat_write_q <= 1'b0;
         lat_data_q  <= 16'd0;
         av_readdata <= 16'd0;
         timeout     <= 1'b0;
      end else begin
         if (state_d != state_q)  phase_q <= phase_len(state_d);
         else if (!phase_last)    phase_q <= phase_q - 4'd1;

         if (state_q == S_WAIT_RDY) rdy_cnt_q <= rdy_cnt_q + 10'd1;
         else                       rdy_cnt_q <= 10'd0;

         if (state_q == S_IDLE) begin
            if (req & present) begin
               lat_addr_q  <= av_address;
               lat_write_q <= ~av_write_n;
               lat_data_q  <= av_writedata;
               timeout     <= 1'b0;
            end else if (req) begin
               av_readdata <= 16'hFFFF;
            end
         end else if (abort) begin
            av_readdata <= 16'hFFFF;
         end else if (to_hit) begin
            timeout <= 1'b1;
            if (!lat_write_q) av_readdata <= 16'hFFFF;
         end else if (rd_done & ~lat_write_q) begin
            av_readdata <= data_in;
         end
      end
   end

   // CS and addr settle a full SETUP phase before, and stay a HOLD phase
   // after, any strobe edge.
   always_comb begin
      cs_n    = 2'b11;
      iord_n  = 1'b1;
      iowr_n  = 1'b1;
      data_oe = 1'b0;
      if (bus_on) begin
         cs_n    = {~lat_addr_q[3], lat_addr_q[3]};
         data_oe = lat_write_q;
      end
      if (strobe_on) begin
         iord_n = lat_write_q;
         iowr_n = ~lat_write_q;
      end
      av_waitrequest = req & ~((state_q == S_HOLD) & phase_last)
                           & ~((state_q == S_IDLE) & ~present);
   end

   assign addr      = lat_addr_q[2:0];
   assign data_out  = lat_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cf_pio_sequencer.sv
// Self-checking bench for cf_pio_sequencer: directed scenarios plus randomized
// accesses checked against a timeline model built from the cycle-count rules.
`timescale 1ns/1ps
module tb_cf_pio_sequencer;
   localparam int S = 4, P = 9, H = 2, R = 7, TO = 1023, MAXC = 2048;

   logic        clk = 1'b0;
   logic        reset_n, present, av_chipselect_n, av_read_n, av_write_n, iordy;
   logic [3:0]  av_address;
   logic [15:0] av_writedata, data_in;
   logic [15:0] av_readdata, data_out;
   logic        av_waitrequest, timeout, iord_n, iowr_n, data_oe;
   logic [2:0]  addr, dbg_state;
   logic [1:0]  cs_n;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   logic        obs_iord[MAXC], obs_iowr[MAXC], obs_wait[MAXC], obs_oe[MAXC], obs_to[MAXC];
   logic [1:0]  obs_cs[MAXC];
   logic [2:0]  obs_addr[MAXC];
   logic [15:0] obs_rd[MAXC], obs_dout[MAXC];

   always #5 clk = ~clk;

   cf_pio_sequencer dut (
      .clk(clk), .reset_n(reset_n), .present(present),
      .av_address(av_address), .av_chipselect_n(av_chipselect_n),
      .av_read_n(av_read_n), .av_write_n(av_write_n), .av_writedata(av_writedata),
      .av_readdata(av_readdata), .av_waitrequest(av_waitrequest), .timeout(timeout),
      .addr(addr), .cs_n(cs_n), .iord_n(iord_n), .iowr_n(iowr_n),
      .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .iordy(iordy),
      .dbg_state(dbg_state)
   );

   // Reference timeline: cycle 0 is the accepting IDLE cycle, SETUP follows,
   // the strobe is low for P + w cycles, completion is the last HOLD cycle.
   // w counts IORDY-low samples from the last nominal strobe cycle onward.
   function automatic int m_wait(input int low_until);
      int n;
      n = low_until - (S + P) + 1;
      if (n < 0)  n = 0;
      if (n > TO) n = TO;
      return n;
   endfunction

   function automatic int m_done(input int w);
      return S + P + w + H;
   endfunction

   // iordy is low for cycles S+1..low_until; present drops from cycle drop_at.
   task automatic do_access(input logic wr, input logic [3:0] a, input logic [15:0] wd,
                            input logic [15:0] din, input int low_until, input int drop_at,
                            output int done, output int lc);
      done = -1;
      lc   = 0;
      @(posedge clk); #1;
      av_address = a; av_writedata = wd; data_in = din;
      av_chipselect_n = 1'b0; av_read_n = wr; av_write_n = ~wr;
      for (int c = 0; c < MAXC; c++) begin
         iordy   = !(c >= S + 1 && c <= low_until);
         present = (drop_at < 0) || (c < drop_at);
         if (done >= 0) begin
            av_chipselect_n = 1'b1; av_read_n = 1'b1; av_write_n = 1'b1;
         end
         @(negedge clk);
         obs_iord[c] = iord_n;  obs_iowr[c] = iowr_n; obs_wait[c] = av_waitrequest;
         obs_oe[c]   = data_oe; obs_to[c]   = timeout; obs_cs[c]  = cs_n;
         obs_addr[c] = addr;    obs_rd[c]   = av_readdata; obs_dout[c] = data_out;
         lc = c;
         if (done < 0 && !av_waitrequest) done = c;
         if (done >= 0 && c >= done + R + 1) break;
         @(posedge clk); #1;
      end
      av_chipselect_n = 1'b1; av_read_n = 1'b1; av_write_n = 1'b1;
      present = 1'b1; iordy = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; present = 1'b1; iordy = 1'b1;
      av_chipselect_n = 1'b1; av_read_n = 1'b1; av_write_n = 1'b1;
      av_address = 4'h0; av_writedata = 16'h0; data_in = 16'h0;
      repeat (2) @(negedge clk);
      total++;
      if ({cs_n, iord_n, iowr_n, addr, data_out, data_oe, av_readdata, timeout, av_waitrequest}
          !== {2'b11, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values got cs=%b rd=%b wr=%b a=%h do=%h oe=%b rdata=%h to=%b wait=%b",
                  cs_n, iord_n, iowr_n, addr, data_out, data_oe, av_readdata, timeout, av_waitrequest);
      end
      av_chipselect_n = 1'b0; av_read_n = 1'b0; #1;
      total++;
      if (av_waitrequest !== 1'b1) begin
         bad++; $display("FAIL reset_wait_follows_req got=%b exp=1", av_waitrequest);
      end
      present = 1'b0; #1;
      total++;
      if (av_waitrequest !== 1'b0) begin
         bad++; $display("FAIL reset_wait_nocard got=%b exp=0", av_waitrequest);
      end
      av_chipselect_n = 1'b1; av_read_n = 1'b1; present = 1'b1;
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({cs_n, iord_n, iowr_n, data_oe} !== 5'b11110) begin
         bad++; $display("FAIL reset_release_idle got=%b exp=11110", {cs_n, iord_n, iowr_n, data_oe});
      end
   endtask

   task automatic test_default_read();
      int done, lc, d;
      logic [4:0] ev;
      d = m_done(0);
      do_access(1'b0, 4'h7, 16'h0000, 16'h50A5, -1, -1, done, lc);
      total++;
      if (done !== d) begin bad++; $display("FAIL default_read_done got=%0d exp=%0d", done, d); end
      for (int c = 0; c <= lc; c++) begin
         ev = {!(c >= S + 1 && c <= S + P), 1'b1, (c >= 1 && c <= d) ? 2'b10 : 2'b11, c < d};
         total++;
         if ({obs_iord[c], obs_iowr[c], obs_cs[c], obs_wait[c]} !== ev) begin
            bad++;
            $display("FAIL default_read_cycle c=%0d got=%b exp=%b", c,
                     {obs_iord[c], obs_iowr[c], obs_cs[c], obs_wait[c]}, ev);
         end
      end
      total++;
      if (obs_rd[14] !== 16'h50A5 || obs_rd[15] !== 16'h50A5) begin
         bad++; $display("FAIL default_read_data got=%h/%h exp=50a5", obs_rd[14], obs_rd[15]);
      end
      total++;
      if (obs_addr[1] !== 3'h7 || obs_to[lc] !== 1'b0) begin
         bad++; $display("FAIL default_read_addr got=%h to=%b exp=7 to=0", obs_addr[1], obs_to[lc]);
      end
   endtask

   task automatic test_write_cs1();
      int done, lc, d, nlow;
      logic [4:0] ev;
      d = m_done(0);
      nlow = 0;
      do_access(1'b1, 4'hE, 16'h00EF, 16'h1234, -1, -1, done, lc);
      total++;
      if (done !== d) begin bad++; $display("FAIL write_done got=%0d exp=%0d", done, d); end
      for (int c = 0; c <= lc; c++) begin
         if (!obs_iowr[c]) nlow++;
         ev = {1'b1, !(c >= S + 1 && c <= S + P), (c >= 1 && c <= d) ? 2'b01 : 2'b11, c >= 1 && c <= d};
         total++;
         if ({obs_iord[c], obs_iowr[c], obs_cs[c], obs_oe[c]} !== ev) begin
            bad++;
            $display("FAIL write_cycle c=%0d got=%b exp=%b", c,
                     {obs_iord[c], obs_iowr[c], obs_cs[c], obs_oe[c]}, ev);
         end
         if (c >= 1 && c <= d) begin
            total++;
            if (obs_dout[c] !== 16'h00EF || obs_addr[c] !== 3'h6) begin
               bad++; $display("FAIL write_bus c=%0d got=%h a=%h exp=00ef a=6", c, obs_dout[c], obs_addr[c]);
            end
         end
      end
      total++;
      if (nlow !== P) begin bad++; $display("FAIL write_strobe_len got=%0d exp=%0d", nlow, P); end
   endtask

   task automatic test_iordy_stretch();
      int done, lc, w, nlow;
      nlow = 0;
      w = m_wait(S + 19);
      do_access(1'b0, 4'h3, 16'h0000, 16'h3C3C, S + 19, -1, done, lc);
      for (int c = 0; c <= lc; c++) begin
         if (!obs_iord[c]) nlow++;
         total++;
         if (obs_iord[c] !== !(c >= S + 1 && c <= S + P + w)) begin
            bad++; $display("FAIL stretch_strobe c=%0d got=%b", c, obs_iord[c]);
         end
      end
      total++;
      if (nlow !== 20 || nlow !== P + w) begin
         bad++; $display("FAIL stretch_len got=%0d exp=20", nlow);
      end
      total++;
      if (done !== m_done(w)) begin bad++; $display("FAIL stretch_done got=%0d exp=%0d", done, m_done(w)); end
      if (done >= 0) begin
         total++;
         if (obs_to[done] !== 1'b0 || obs_rd[done] !== 16'h3C3C) begin
            bad++; $display("FAIL stretch_result got to=%b rd=%h exp to=0 rd=3c3c", obs_to[done], obs_rd[done]);
         end
      end
   endtask

   task automatic test_iordy_timeout();
      int done, lc, nlow;
      nlow = 0;
      do_access(1'b0, 4'h0, 16'h0000, 16'h1234, 4 * MAXC, -1, done, lc);
      for (int c = 0; c <= lc; c++) if (!obs_iord[c]) nlow++;
      total++;
      if (nlow !== P + TO) begin bad++; $display("FAIL timeout_len got=%0d exp=%0d", nlow, P + TO); end
      total++;
      if (done !== m_done(TO)) begin bad++; $display("FAIL timeout_done got=%0d exp=%0d", done, m_done(TO)); end
      if (done >= 0) begin
         total++;
         if ({obs_to[S], obs_to[done], obs_rd[done]} !== {1'b0, 1'b1, 16'hFFFF}) begin
            bad++; $display("FAIL timeout_flag got to=%b/%b rd=%h exp to=0/1 rd=ffff",
                            obs_to[S], obs_to[done], obs_rd[done]);
         end
      end
      do_access(1'b0, 4'h1, 16'h0000, 16'h0F0F, -1, -1, done, lc);
      total++;
      if ({obs_to[0], obs_to[1]} !== 2'b10) begin
         bad++; $display("FAIL timeout_clear got=%b exp=10", {obs_to[0], obs_to[1]});
      end
      total++;
      if (done !== m_done(0) || obs_rd[m_done(0)] !== 16'h0F0F) begin
         bad++; $display("FAIL timeout_next_read got done=%0d rd=%h exp done=%0d rd=0f0f",
                         done, obs_rd[m_done(0)], m_done(0));
      end
   endtask

   task automatic test_no_card();
      int done, lc;
      do_access(1'b0, 4'h3, 16'h0000, 16'h7777, -1, 0, done, lc);
      total++;
      if (done !== 0 || obs_wait[0] !== 1'b0) begin
         bad++; $display("FAIL nocard_wait got done=%0d wait=%b exp done=0 wait=0", done, obs_wait[0]);
      end
      total++;
      if (obs_rd[1] !== 16'hFFFF) begin bad++; $display("FAIL nocard_data got=%h exp=ffff", obs_rd[1]); end
      for (int c = 0; c <= lc; c++) begin
         total++;
         if ({obs_cs[c], obs_iord[c], obs_iowr[c], obs_oe[c]} !== 5'b11110) begin
            bad++; $display("FAIL nocard_idle c=%0d got=%b exp=11110", c,
                            {obs_cs[c], obs_iord[c], obs_iowr[c], obs_oe[c]});
         end
      end
   endtask

   task automatic test_removal();
      int done, lc, drop;
      drop = S + 5;
      do_access(1'b0, 4'h1, 16'h0000, 16'hA5A5, -1, drop, done, lc);
      total++;
      if (done !== drop + H) begin bad++; $display("FAIL removal_done got=%0d exp=%0d", done, drop + H); end
      for (int c = 0; c <= lc; c++) begin
         total++;
         if ({obs_iord[c], obs_cs[c]} !== {!(c >= S + 1 && c <= drop), (c >= 1 && c <= drop + H) ? 2'b10 : 2'b11}) begin
            bad++; $display("FAIL removal_cycle c=%0d got=%b", c, {obs_iord[c], obs_cs[c]});
         end
      end
      if (done >= 0) begin
         total++;
         if (obs_rd[done] !== 16'hFFFF || obs_to[done] !== 1'b0) begin
            bad++; $display("FAIL removal_result got rd=%h to=%b exp rd=ffff to=0", obs_rd[done], obs_to[done]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2;
      d1 = -1; d2 = -1;
      @(posedge clk); #1;
      iordy = 1'b1; present = 1'b1; av_address = 4'h2; data_in = 16'h1111;
      av_chipselect_n = 1'b0; av_read_n = 1'b0; av_write_n = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (d1 >= 0 && c > d1 && c <= d1 + R + 1) begin
            total++;
            if ({cs_n, av_waitrequest} !== 3'b111) begin
               bad++; $display("FAIL b2b_stall c=%0d got=%b exp=111", c, {cs_n, av_waitrequest});
            end
         end
         if (!av_waitrequest) begin
            if (d1 < 0) begin
               d1 = c;
               total++;
               if (av_readdata !== 16'h1111) begin bad++; $display("FAIL b2b_data1 got=%h exp=1111", av_readdata); end
            end else begin
               d2 = c;
               break;
            end
         end
         @(posedge clk); #1;
         if (c == d1) begin av_address = 4'hA; data_in = 16'h2222; end
      end
      total++;
      if (d1 !== m_done(0) || d2 !== d1 + m_done(0) + R + 1) begin
         bad++; $display("FAIL b2b_timing got d1=%0d d2=%0d exp d1=%0d d2=%0d",
                         d1, d2, m_done(0), 2 * m_done(0) + R + 1);
      end
      total++;
      if ({av_readdata, cs_n} !== {16'h2222, 2'b01}) begin
         bad++; $display("FAIL b2b_data2 got rd=%h cs=%b exp rd=2222 cs=01", av_readdata, cs_n);
      end
      av_chipselect_n = 1'b1; av_read_n = 1'b1;
      repeat (R + 2) @(posedge clk);
   endtask

   task automatic test_random();
      logic wr;
      logic [3:0] a;
      logic [15:0] wd, din, ex;
      int lu, w, done, lc, nsel, noth;
      for (int k = 0; k < 12; k++) begin
         wr  = 1'($urandom_range(0, 1));
         a   = 4'($urandom_range(0, 15));
         wd  = 16'($urandom);
         din = 16'($urandom);
         lu  = int'($urandom_range(0, S + P + 25));
         w   = m_wait(lu);
         if (!wr) exp_q.push_back(din);
         do_access(wr, a, wd, din, lu, -1, done, lc);
         nsel = 0; noth = 0;
         for (int c = 0; c <= lc; c++) begin
            if (!(wr ? obs_iowr[c] : obs_iord[c])) nsel++;
            if (!(wr ? obs_iord[c] : obs_iowr[c])) noth++;
         end
         total++;
         if (done !== m_done(w) || nsel !== P + w || noth !== 0) begin
            bad++; $display("FAIL rand_timing k=%0d got done=%0d low=%0d other=%0d exp done=%0d low=%0d other=0",
                            k, done, nsel, noth, m_done(w), P + w);
         end
         total++;
         if ({obs_cs[1], obs_addr[1]} !== {~a[3], a[3], a[2:0]}) begin
            bad++; $display("FAIL rand_addr k=%0d got cs=%b a=%h exp a=%h", k, obs_cs[1], obs_addr[1], a);
         end
         if (wr) begin
            total++;
            if ({obs_oe[S + 1], obs_dout[S + 1]} !== {1'b1, wd}) begin
               bad++; $display("FAIL rand_wdata k=%0d got oe=%b d=%h exp oe=1 d=%h", k, obs_oe[S + 1], obs_dout[S + 1], wd);
            end
         end else begin
            ex = exp_q.pop_front();
            total++;
            if (done < 0 || obs_rd[done < 0 ? 0 : done] !== ex) begin
               bad++; $display("FAIL rand_rdata k=%0d got=%h exp=%h", k, obs_rd[done < 0 ? 0 : done], ex);
            end
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      @(posedge clk); #1;
      iordy = 1'b1; present = 1'b1; av_address = 4'h5; av_writedata = 16'hBEEF;
      av_chipselect_n = 1'b0; av_read_n = 1'b1; av_write_n = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      total++;
      if ({iowr_n, data_oe} !== 2'b01) begin bad++; $display("FAIL rst_pulse_pre got=%b exp=01", {iowr_n, data_oe}); end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({iord_n, iowr_n, cs_n, data_oe, addr, data_out} !== {1'b1, 1'b1, 2'b11, 1'b0, 3'd0, 16'd0}) begin
         bad++; $display("FAIL rst_pulse_async got rd=%b wr=%b cs=%b oe=%b a=%h d=%h",
                         iord_n, iowr_n, cs_n, data_oe, addr, data_out);
      end
      av_chipselect_n = 1'b1; av_write_n = 1'b1;
      @(posedge clk); #1 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if ({iord_n, iowr_n, cs_n} !== 4'b1111) begin
            bad++; $display("FAIL rst_pulse_after c=%0d got=%b exp=1111", i, {iord_n, iowr_n, cs_n});
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_read();
      test_write_cs1();
      test_iordy_stretch();
      test_iordy_timeout();
      test_no_card();
      test_removal();
      test_back_to_back();
      test_random();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
